// File: rtl/wb_burst_master_pkg.sv
// Shared constants, status codes and FSM state encoding for wb_burst_master.
// Consumed by the top-level module through a package import.
package wb_burst_master_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

endpackage

// File: rtl/wb_burst_master_wdog.sv
// Stall watchdog: counts consecutive unanswered strobe cycles.
// Only instantiated when WB_BURST_MASTER_TIMEOUT_EN is defined.
module wb_burst_master_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic expired
);

    logic [7:0] cnt;

    // Fires on the TIMEOUT-th consecutive stall cycle.
    assign expired = stall && (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (!stall) begin
            cnt <= 8'd0;
        end else if (!expired) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// WISHBONE B3 incrementing-burst initiator with bounded retry.
// Optional stall watchdog enabled by defining WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master
    import wb_burst_master_pkg::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [4:0]  cmd_len,
    input  logic [3:0]  cmd_sel,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t        state;
    logic [31:0]   adr;
    logic [4:0]    rem;
    logic [RW-1:0] rty_cnt;
    logic          we;
    logic          single;
    logic [3:0]    sel;
    logic [2:0]    cti;
    logic [1:0]    st;

    logic [4:0] len_eff;
    logic       stb;
    logic       ack;
    logic       err;
    logic       rty;
    logic       tmo;

    assign len_eff = (cmd_len == 5'd0)          ? 5'd1 :
                     (cmd_len > 5'(MAX_LEN))    ? 5'(MAX_LEN) : cmd_len;

    assign stb = (state == S_BURST) && (we ? wr_valid : 1'b1);
    // err outranks rty, rty outranks ack.
    assign err = stb && wb_err_i;
    assign rty = stb && wb_rty_i && !wb_err_i;
    assign ack = stb && wb_ack_i && !wb_err_i && !wb_rty_i;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    wb_burst_master_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stb && !wb_ack_i && !wb_err_i && !wb_rty_i),
        .expired (tmo)
    );
`else
    assign tmo = 1'b0 & (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            adr     <= 32'd0;
            rem     <= 5'd0;
            rty_cnt <= '0;
            we      <= 1'b0;
            single  <= 1'b0;
            sel     <= 4'd0;
            cti     <= CTI_CLASSIC;
            st      <= ST_OK;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        adr     <= {cmd_adr[31:2], 2'b00};
                        rem     <= len_eff;
                        we      <= cmd_we;
                        sel     <= cmd_sel;
                        rty_cnt <= '0;
                        single  <= (len_eff == 5'd1);
                        cti     <= (len_eff == 5'd1) ? CTI_CLASSIC : CTI_INCR;
                        state   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (err) begin
                        st    <= ST_ERR;
                        state <= S_DONE;
                    end else if (rty) begin
                        if (rty_cnt == RW'(MAX_RETRY)) begin
                            st    <= ST_RTY;
                            state <= S_DONE;
                        end else begin
                            rty_cnt <= rty_cnt + RW'(1);
                            state   <= S_GAP;
                        end
                    end else if (ack) begin
                        adr <= adr + 32'd4;
                        rem <= rem - 5'd1;
                        // cti describes the beat about to be presented next.
                        cti <= single          ? CTI_CLASSIC :
                               (rem == 5'd2)   ? CTI_EOB : CTI_INCR;
                        if (rem == 5'd1) begin
                            st    <= ST_OK;
                            state <= S_DONE;
                        end
                    end else if (tmo) begin
                        st    <= ST_TMO;
                        state <= S_DONE;
                    end
                end
                S_GAP: begin
                    state <= S_BURST;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign status    = st;
    assign wb_cyc_o  = (state == S_BURST);
    assign wb_stb_o  = stb;
    assign wb_we_o   = we;
    assign wb_adr_o  = adr;
    assign wb_sel_o  = sel;
    assign wb_cti_o  = cti;
    assign wb_bte_o  = BTE_LINEAR;
    assign wb_dat_o  = wr_data;
    assign wr_ready  = ack && we;
    assign rd_valid  = ack && !we;
    assign rd_data   = wb_dat_i;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: scripted WB slave plus a
// transaction-level model that predicts beats, status and bus attempts.
module tb_wb_burst_master;

    localparam int RSP_WAIT = 0;
    localparam int RSP_ACK  = 1;
    localparam int RSP_ERR  = 2;
    localparam int RSP_RTY  = 3;

    localparam int M_RAND   = 0;
    localparam int M_ACK    = 1;
    localparam int M_RTY    = 2;
    localparam int M_ERR_AT = 3;
    localparam int M_RTY_AT = 4;
    localparam int M_SILENT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [4:0]  cmd_len = '0;
    logic [3:0]  cmd_sel = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  status;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;

    always #5 clk = ~clk;

    wb_burst_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_len   (cmd_len),
        .cmd_sel   (cmd_sel),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .status    (status),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_cti_o  (wb_cti_o),
        .wb_bte_o  (wb_bte_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_rty_i  (wb_rty_i)
    );

    typedef struct {
        int          code;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [1:0] st;
        int         attempts;
    } end_t;

    rsp_t        script[$];
    beat_t       exp_beats[$];
    end_t        exp_end[$];
    logic [31:0] wq[$];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, req, cycle);
        end
    endtask

    // Write stream source: offers the head of wq with random gaps.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wq.size() > 0 && $urandom_range(0, 3) != 0) begin
                wr_valid = 1'b1;
                wr_data  = wq[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = $urandom;
            end
        end
    end

    // Slave: consumes one scripted response per strobed cycle.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_rty_i = 1'b0;
            wb_dat_i = $urandom;
            if (rst_n && wb_cyc_o && wb_stb_o && script.size() > 0) begin
                r = script.pop_front();
                case (r.code)
                    RSP_ACK: begin
                        wb_ack_i = 1'b1;
                        wb_dat_i = r.data;
                    end
                    RSP_ERR: wb_err_i = 1'b1;
                    RSP_RTY: wb_rty_i = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Monitor: pops expectations whenever the DUT transfers or finishes.
    initial begin
        beat_t b;
        end_t  e;
        int    cur_att;
        int    last_stb;
        logic  prev_cyc;
        cur_att  = 0;
        last_stb = -10;
        prev_cyc = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                cur_att  = 0;
                prev_cyc = 1'b0;
                continue;
            end
            if (wb_cyc_o && !prev_cyc) begin
                if (cur_att > 0)
                    chk("retry_gap", cycle - last_stb, 2);
                cur_att++;
            end
            prev_cyc = wb_cyc_o;
            if (wb_stb_o)
                last_stb = cycle;
            if (wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i) begin
                if (exp_beats.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat_adr", wb_adr_o, b.adr);
                    chk("beat_cti", {29'd0, wb_cti_o}, {29'd0, b.cti});
                    chk("beat_bte", {30'd0, wb_bte_o}, 32'd0);
                    chk("beat_sel", {28'd0, wb_sel_o}, {28'd0, b.sel});
                    chk("beat_we", {31'd0, wb_we_o}, {31'd0, b.we});
                    if (b.we) begin
                        chk("wr_ready", {31'd0, wr_ready}, 32'd1);
                        chk("wr_word", wb_dat_o, b.data);
                        if (wq.size() > 0)
                            void'(wq.pop_front());
                    end else begin
                        chk("rd_valid", {31'd0, rd_valid}, 32'd1);
                        chk("rd_word", rd_data, b.data);
                    end
                end
            end else begin
                chk("stray_pulse", {30'd0, rd_valid, wr_ready}, 32'd0);
            end
            if (done) begin
                done_cnt++;
                chk("done_latency", cycle - last_stb, 1);
                chk("done_ready", {31'd0, cmd_ready}, 32'd0);
                chk("beats_left", exp_beats.size(), 0);
                if (exp_end.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_end.pop_front();
                    chk("status", {30'd0, status}, {30'd0, e.st});
                    chk("attempts", cur_att, e.attempts);
                end
                cur_att = 0;
            end
        end
    end

    // Reference model: builds the slave script and the expected outcome.
    task automatic plan(input logic we, input logic [31:0] adr,
                        input int len, input logic [3:0] sel,
                        input int mode, input int arg);
        int          n;
        int          beats;
        int          retries;
        int          code;
        int          r;
        bit          fin;
        logic [1:0]  st;
        logic [31:0] base;
        logic [31:0] d;
        logic [31:0] words[$];
        n = (len == 0) ? 1 : len;
        beats = 0;
        retries = 0;
        fin = 0;
        st = 2'b00;
        base = {adr[31:2], 2'b00};
        for (int i = 0; i < n; i++)
            words.push_back($urandom);
        if (we)
            foreach (words[i]) wq.push_back(words[i]);
        if (mode == M_SILENT) begin
            exp_end.push_back('{2'b11, 1});
            return;
        end
        while (!fin) begin
            case (mode)
                M_ACK:    code = RSP_ACK;
                M_RTY:    code = RSP_RTY;
                M_ERR_AT: code = (beats == arg) ? RSP_ERR : RSP_ACK;
                M_RTY_AT: code = (beats == arg && retries == 0) ?
                                 RSP_RTY : RSP_ACK;
                default: begin
                    r = $urandom_range(0, 15);
                    code = (r < 4) ? RSP_WAIT : (r == 4) ? RSP_ERR :
                           (r < 7) ? RSP_RTY : RSP_ACK;
                end
            endcase
            if (code == RSP_WAIT) begin
                script.push_back('{RSP_WAIT, 32'd0});
            end else if (code == RSP_ERR) begin
                script.push_back('{RSP_ERR, 32'd0});
                st = 2'b01;
                fin = 1;
            end else if (code == RSP_RTY) begin
                script.push_back('{RSP_RTY, 32'd0});
                if (retries == 3) begin
                    st = 2'b10;
                    fin = 1;
                end else begin
                    retries++;
                end
            end else begin
                d = we ? words[beats] : $urandom;
                script.push_back('{RSP_ACK, d});
                exp_beats.push_back('{
                    base + 32'(4 * beats),
                    (n == 1) ? 3'b000 : (beats == n - 1) ? 3'b111 : 3'b010,
                    we, sel, d});
                beats++;
                if (beats == n) begin
                    st = 2'b00;
                    fin = 1;
                end
            end
        end
        exp_end.push_back('{st, retries + 1});
    endtask

    task automatic send(input logic we, input logic [31:0] adr,
                        input int len, input logic [3:0] sel);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready)
            chk("idle_wait", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = 5'(len);
        cmd_sel   = sel;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("cmd_to_cyc", {31'd0, wb_cyc_o}, 32'd1);
    endtask

    task automatic run(input logic we, input logic [31:0] adr,
                       input int len, input logic [3:0] sel,
                       input int mode, input int arg);
        int start;
        int k;
        plan(we, adr, len, sel, mode, arg);
        start = done_cnt;
        send(we, adr, len, sel);
        k = 0;
        while (done_cnt == start && k < 2000) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == start)
            chk("done_wait", 32'd0, 32'd1);
        @(negedge clk);
        chk("script_used", script.size(), 0);
        script.delete();
        exp_beats.delete();
        wq.delete();
    endtask

    initial begin
        int dc;
        #2;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_status", {30'd0, status}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_cti", {29'd0, wb_cti_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 32'h4000_0000, 4, 4'hF, M_ACK, 0);
        run(1'b1, 32'h0000_1000, 3, 4'h3, M_ACK, 0);
        run(1'b0, 32'h0000_2004, 1, 4'hF, M_ACK, 0);
        run(1'b0, 32'h0000_3000, 4, 4'hF, M_RTY_AT, 2);
        run(1'b0, 32'h0000_4000, 2, 4'hF, M_RTY_AT, 1);
        run(1'b0, 32'h0000_5000, 4, 4'hF, M_RTY, 0);
        run(1'b0, 32'h0000_6000, 4, 4'hF, M_ERR_AT, 1);
        run(1'b1, 32'h0000_7000, 5, 4'hC, M_ERR_AT, 3);
        run(1'b0, 32'hFFFF_FFF7, 4, 4'hF, M_ACK, 0);
        run(1'b1, 32'h0000_8000, 0, 4'h1, M_ACK, 0);
        run(1'b1, 32'h0000_9000, 16, 4'hF, M_ACK, 0);
        for (int i = 0; i < 60; i++)
            run(1'($urandom), $urandom, $urandom_range(0, 16),
                4'($urandom), M_RAND, 0);
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        run(1'b0, 32'h0000_A000, 4, 4'hF, M_SILENT, 0);
`endif

        // Asynchronous reset while a burst is stalled.
        dc = done_cnt;
        send(1'b0, 32'h0000_B000, 8, 4'hF);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("midrst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_done", done_cnt, dc);
        chk("midrst_idle", {31'd0, cmd_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
